// File: rtl/mmio_uart.sv
// ============================================================================
// Module   : mmio_uart
// Purpose  : Memory-mapped transmit-only UART (8N1) with a small TX FIFO,
//            sitting on the single-cycle MIPS data-memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,   // asynchronous, active-low
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  C_DEPTH  = 5'(FIFO_DEPTH);
  localparam logic [15:0] C_BAUD   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_shift;
  logic [15:0]     r_baud;
  logic [2:0]      r_bit;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [4:0]      r_count;
  logic            r_irq_en;
  logic            r_tx_en;
  logic [7:0]      r_dropped;

  logic            w_wr;
  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic [25:0]     w_unused_bits;

  // Address decode and FIFO/handshake conditions
  assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr       = we & sel;
  assign w_full     = (r_count == C_DEPTH);
  assign w_empty    = (r_count == 5'd0);
  assign w_busy     = (r_state != ST_IDLE);
  assign w_pop      = (r_state == ST_IDLE) & r_tx_en & ~w_empty;
  assign w_push_req = w_wr & (addr[3:2] == 2'd0);
  // A simultaneous pop frees a slot, so a full FIFO can still accept
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push;
  assign w_unused_bits = {addr[1:0], wdata[31:8]};

  // Combinational register read-back, zero when not selected
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (addr[3:2])
        2'd1:    rdata = {19'd0, r_count, 5'd0, w_busy, w_empty, w_full};
        2'd2:    rdata = {30'd0, r_tx_en, r_irq_en};
        2'd3:    rdata = {24'd0, r_dropped};
        default: rdata = 32'd0;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata[7:0];
  end

  // FIFO pointers, occupancy, control, drop counter and interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= 5'd0;
      r_irq_en  <= 1'b0;
      r_tx_en   <= 1'b1;
      r_dropped <= 8'd0;
      irq       <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_wr && addr[3:2] == 2'd2) begin
        r_irq_en <= wdata[0];
        r_tx_en  <= wdata[1];
      end
      if (w_wr && addr[3:2] == 2'd3) begin
        r_dropped <= 8'd0;
      end else if (w_drop && r_dropped != 8'hFF) begin
        r_dropped <= r_dropped + 8'd1;
      end
      irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  // Serializer: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_shift <= 8'd0;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      txd     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_baud  <= C_BAUD;
            txd     <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_baud == 16'd0) begin
            r_baud  <= C_BAUD;
            r_bit   <= 3'd0;
            txd     <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        ST_DATA: begin
          if (r_baud == 16'd0) begin
            r_baud <= C_BAUD;
            if (r_bit == 3'd7) begin
              txd     <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              txd     <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        ST_STOP: begin
          if (r_baud == 16'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          txd     <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart.sv
// ============================================================================
// Module   : tb_mmio_uart
// Purpose  : Scoreboard bench for mmio_uart (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_uart;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        sel;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] sb_q [$];     // bytes expected on the line, in order
  int         starts [$];   // cycle of each observed start-bit fall
  logic [7:0] bytes_q [$];  // bytes written in the current round
  bit         mon_en   = 1'b1;
  bit         mon_busy = 1'b0;

  mmio_uart #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .sel  (sel),
    .rdata(rdata),
    .txd  (txd),
    .irq  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data);
    @(negedge clk);
    addr  = BASE | {28'd0, off};
    wdata = data;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] off, input logic [31:0] exp);
    @(negedge clk);
    addr = BASE | {28'd0, off};
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL tx_timeout got=%0d pending exp=0", sb_q.size());
    end
  endtask

  // Monitor: capture each frame from its start bit and score it against the queue
  initial begin : monitor
    logic [39:0] samp;
    logic [39:0] expw;
    logic [7:0]  b;
    logic [7:0]  got;
    int          mism;
    forever begin
      @(negedge clk);
      if (mon_en && reset === 1'b1 && txd === 1'b0) begin
        mon_busy = 1'b1;
        starts.push_back(cyc);
        samp = '0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          samp[i] = txd;
        end
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got=frame exp=none (cycle %0d)", cyc);
        end else begin
          b = sb_q.pop_front();
          // Ideal line: 0 start, data LSB first, 1 stop, each CPB cycles
          for (int i = 0; i < FRAME; i++) begin
            if (i / CPB == 0)      expw[i] = 1'b0;
            else if (i / CPB == 9) expw[i] = 1'b1;
            else                   expw[i] = b[i / CPB - 1];
          end
          mism = 0;
          for (int i = 0; i < FRAME; i++) if (samp[i] !== expw[i]) mism++;
          for (int j = 0; j < 8; j++) got[j] = samp[CPB * (j + 1) + CPB / 2];
          chk("frame_data", got, b);
          chk("frame_shape_mismatches", mism, 0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  // One round: load bytes with transmit disabled, check occupancy/drops, then release
  task automatic round(input string tag);
    int n, acc, drop, base, e;
    logic [31:0] st;
    n    = bytes_q.size();
    acc  = (n < DEPTH) ? n : DEPTH;
    drop = n - acc;
    wr(4'h8, 32'h0);
    foreach (bytes_q[i]) wr(4'h0, {24'd0, bytes_q[i]});
    st = (acc << 8) | ((acc == 0) ? 32'h2 : 32'h0) | ((acc == DEPTH) ? 32'h1 : 32'h0);
    rd_chk({tag, "_status_loaded"}, 4'h4, st);
    rd_chk({tag, "_dropped"}, 4'hC, drop);
    rd_chk({tag, "_ctrl_off"}, 4'h8, 32'h0);
    wr(4'hC, $urandom);
    rd_chk({tag, "_dropped_clr"}, 4'hC, 32'h0);
    for (int i = 0; i < acc; i++) sb_q.push_back(bytes_q[i]);
    base = starts.size();
    wr(4'h8, 32'h2);
    e = cyc;
    wait_done(acc * (FRAME + 1) + 50);
    repeat (2) @(negedge clk);
    rd_chk({tag, "_status_idle"}, 4'h4, 32'h2);
    chk({tag, "_frame_count"}, starts.size() - base, acc);
    if (acc > 0 && starts.size() >= base + acc) begin
      chk({tag, "_first_start"}, starts[base], e + 1);
      for (int i = 1; i < acc; i++)
        chk({tag, "_b2b_spacing"}, starts[base + i] - starts[base + i - 1], FRAME + 1);
    end
  endtask

  initial begin : main
    int e, cnt, firstk, lows;
    reset = 1'b0;
    addr  = 32'h0000_1000;
    wdata = 32'h0;
    we    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_txd_held", txd, 1'b1);
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    chk("reset_sel_off", sel, 1'b0);
    chk("reset_rdata_off", rdata, 32'h0);
    chk("reset_txd", txd, 1'b1);
    chk("reset_irq", irq, 1'b0);
    rd_chk("reset_status", 4'h4, 32'h2);
    chk("sel_on", sel, 1'b1);
    rd_chk("reset_ctrl", 4'h8, 32'h2);
    rd_chk("reset_dropped", 4'hC, 32'h0);
    rd_chk("txdata_reads_zero", 4'h0, 32'h0);

    // Single byte 0x55 with transmit already enabled
    sb_q.push_back(8'h55);
    wr(4'h0, 32'h55);
    e = cyc;
    addr = BASE | 32'h4;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdata[2]) cnt++;
    end
    chk("single_busy_cycles", cnt, FRAME);
    wait_done(100);
    chk("single_first_start", starts[starts.size() - 1], e + 1);

    // Overflow: six writes into a four-deep FIFO
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    round("overflow");

    // Back-to-back pair
    bytes_q = '{8'hA5, 8'h3C};
    round("b2b");

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(0, 7);
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
      round("rand");
    end

    // Interrupt rise and fall
    wr(4'h8, 32'h0);
    sb_q.push_back(8'h96);
    wr(4'h0, 32'h96);
    chk("irq_disabled", irq, 1'b0);
    wr(4'h8, 32'h3);
    firstk = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (irq && firstk < 0) firstk = k;
    end
    chk("irq_rise_delay", firstk, FRAME + 2);
    wait_done(100);
    wr(4'h8, 32'h2);
    @(negedge clk);
    chk("irq_hold_one_cycle", irq, 1'b1);
    @(negedge clk);
    chk("irq_fall", irq, 1'b0);

    // Reset during DATA bit 3
    mon_en = 1'b0;
    wr(4'h0, 32'h00);
    for (int k = 0; k <= 18; k++) @(negedge clk);
    chk("pre_reset_txd_low", txd, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1'b1);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    rd_chk("post_reset_status", 4'h4, 32'h2);
    rd_chk("post_reset_ctrl", 4'h8, 32'h2);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("no_residual_frame", lows, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mmio_uart.md
# mmio_uart

Memory-mapped transmit-only UART peripheral on the single-cycle MIPS data-memory port, downstream of the processor core. It decodes the core's data address, write enable and write data, and buffers bytes in a small TX FIFO. It serializes them 8N1 on `txd`. It returns status and control words combinationally, so the top level can mux them into the core's read data in the same cycle.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: base of the 16-byte register window; low 4 bits must be zero.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; range 2..65535.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, 2..16.

Ports:
- `clk` input 1: the single system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low (the codebase's `reset` name); low clears all state immediately.
- `addr` input 32: data address from the core's ALU output.
- `wdata` input 32: store data from the core.
- `we` input 1: memory write strobe from the core.
- `sel` output 1: combinational; 1 when `addr[31:4] == BASE_ADDR[31:4]`.
- `rdata` output 32: combinational read word; 0 when `sel`=0.
- `txd` output 1: serial line; idles high.
- `irq` output 1: registered transmit-idle interrupt.

## Operation
- Register map (word index = `addr[3:2]`; `addr[1:0]` ignored):
  - +0x0 TXDATA: write pushes `wdata[7:0]`; reads return 0.
  - +0x4 STATUS: read-only; bit0 full, bit1 empty, bit2 busy, bits[12:8] FIFO count; other bits 0.
  - +0x8 CTRL: read/write; bit0 irq_en, bit1 tx_en; other bits are written as ignored and read as 0.
  - +0xC DROPPED: 8-bit count of rejected pushes in bits[7:0], saturating at 255; any write clears it to 0.
- A write takes effect when `we & sel` is high at a rising edge. Writes to read-only STATUS are ignored.
- A push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise the byte is discarded and DROPPED increments.
- FIFO: circular buffer; read and write pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
- TX state machine: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If tx_en=1 and the FIFO is non-empty, pop the head into the shift register, load the baud counter, and go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for CLKS_PER_BIT cycles, then shift right. After 8 bits (LSB first), go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- busy = (state != IDLE).
- `irq` is registered as irq_en & empty & ~busy.
- Clearing tx_en mid-frame lets the current frame finish; no further pops occur while tx_en=0.
- Reset values: state IDLE, `txd`=1, FIFO empty, pointers 0, DROPPED 0, CTRL=0x2 (tx_en=1, irq_en=0), `irq`=0.

## Timing
- `sel` and `rdata` are pure combinational functions of `addr` and current register state. STATUS reflects state before the current edge's update.
- A push at edge N makes count=1 visible after N. The IDLE pop happens at edge N+1, and `txd` falls after N+1.
- One frame spans exactly 10·CLKS_PER_BIT cycles, from the `txd` fall to the end of STOP.
- Back-to-back frames have exactly one IDLE cycle (`txd`=1) between the end of STOP and the next start bit.
- Simultaneous push and pop on a full FIFO: count stays FIFO_DEPTH and DROPPED is unchanged.
- Reset asserted mid-frame: `txd`=1 immediately (asynchronously), the FIFO is flushed, and the partial frame is lost.
- After reset deasserts, operation resumes at the first rising edge.
- `irq` lags its condition by one cycle.

## Test plan
- Reset check: pulse `reset` low -> `txd`=1, `irq`=0, STATUS=0x0000_0002, CTRL=0x2, DROPPED=0. With `addr`=0x0000_1000: `sel`=0, `rdata`=0.
- Single byte, CLKS_PER_BIT=4: write 0x55 to +0x0 -> `txd` shows start 0, then 1,0,1,0,1,0,1,0, then stop 1. Each bit lasts 4 cycles; the frame is 40 cycles; STATUS.busy=1 throughout.
- Overflow, FIFO_DEPTH=4, tx_en=0: six writes -> STATUS full=1, count=4, DROPPED=2. A write to +0xC -> DROPPED=0.
- Back-to-back: push 0xA5 and 0x3C, then set tx_en -> two 40-cycle frames separated by exactly one high cycle; LSB-first data matches.
- Interrupt: set CTRL=0x3 and send one byte -> `irq` rises one cycle after the FIFO is empty and the state returns to IDLE. Writing CTRL=0x2 makes `irq` fall on the next cycle.
- Reset mid-frame: assert `reset` during DATA bit 3 -> `txd`=1 without waiting for a clock edge. After release, STATUS=0x2 and no residual frame is sent.
